// File: rtl/pc_sp_update_unit_if.sv
// Command/status bus of the PC/SP update engine. The stack_limit input exists
// only when PC_SP_STACK_LIMIT_EN is defined.
interface pc_sp_update_unit_if #(
    parameter int WIDTH = 16,
    parameter int IMM_W = 10
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [IMM_W-1:0] cmd_imm;
    logic [WIDTH-1:0] cmd_data;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] sp_out;
    logic             done;
    logic             fault;
    logic [1:0]       fault_code;
    logic             fault_clear;
`ifdef PC_SP_STACK_LIMIT_EN
    logic [WIDTH-1:0] stack_limit;
`endif

    modport master (
        output cmd_valid, cmd_op, cmd_imm, cmd_data, fault_clear,
`ifdef PC_SP_STACK_LIMIT_EN
        output stack_limit,
`endif
        input  cmd_ready, pc_out, sp_out, done, fault, fault_code
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_imm, cmd_data, fault_clear,
`ifdef PC_SP_STACK_LIMIT_EN
        input  stack_limit,
`endif
        output cmd_ready, pc_out, sp_out, done, fault, fault_code
    );
endinterface

// File: rtl/pc_sp_update_unit.sv
// Registered PC/SP update engine: one command per two cycles, sticky alignment fault.
// Optional SP lower-bound fault enabled by defining PC_SP_STACK_LIMIT_EN.
module pc_sp_update_unit #(
    parameter int               WIDTH     = 16,
    parameter int               IMM_W     = 10,
    parameter int               IMM_SHIFT = 1,
    parameter logic [WIDTH-1:0] PC_RESET  = 16'h0000,
    parameter logic [WIDTH-1:0] SP_RESET  = 16'hFFFE,
    parameter int               PC_STEP   = 2
) (
    input logic               clk,
    input logic               reset,
    pc_sp_update_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_EXEC  = 2'b01,
        S_FAULT = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD_SP_IMM = 2'b00,
        OP_ADD_PC_IMM = 2'b01,
        OP_PC_INC     = 2'b10,
        OP_LOAD_PC    = 2'b11
    } op_e;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
`ifdef PC_SP_STACK_LIMIT_EN
    localparam logic [1:0] FC_SP_LIMIT = 2'b10;
`endif

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] sp_q, sp_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;
    logic [1:0]       code_q, code_d;

    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] result;
    logic             writes_sp;
    logic             misalign;
    logic             sp_limit_hit;

    // Extension happens at accept time so the command register holds a ready operand.
    assign imm_sext = {{(WIDTH-IMM_W){bus.cmd_imm[IMM_W-1]}}, bus.cmd_imm};
    assign imm_ext  = imm_sext << IMM_SHIFT;

    assign writes_sp = (op_q == OP_ADD_SP_IMM);

    always_comb begin
        base = pc_q;
        unique case (op_q)
            OP_ADD_SP_IMM: base = sp_q;
            OP_ADD_PC_IMM: base = pc_q;
            OP_PC_INC:     base = pc_q;
            OP_LOAD_PC:    base = '0;
        endcase
    end

    assign result   = base + operand_q;
    assign misalign = !writes_sp && result[0];

`ifdef PC_SP_STACK_LIMIT_EN
    assign sp_limit_hit = writes_sp && (result < bus.stack_limit);
`else
    assign sp_limit_hit = 1'b0;
`endif

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default would infer a latch.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        operand_d = operand_q;
        pc_d      = pc_q;
        sp_d      = sp_q;
        done_d    = 1'b0;
        fault_d   = fault_q;
        code_d    = code_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d = op_e'(bus.cmd_op);
                    unique case (op_e'(bus.cmd_op))
                        OP_ADD_SP_IMM: operand_d = imm_ext;
                        OP_ADD_PC_IMM: operand_d = imm_ext;
                        OP_PC_INC:     operand_d = WIDTH'(PC_STEP);
                        OP_LOAD_PC:    operand_d = bus.cmd_data;
                    endcase
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (misalign) begin
                    fault_d = 1'b1;
                    code_d  = FC_MISALIGN;
                    state_d = S_FAULT;
                end else if (sp_limit_hit) begin
`ifdef PC_SP_STACK_LIMIT_EN
                    fault_d = 1'b1;
                    code_d  = FC_SP_LIMIT;
                    state_d = S_FAULT;
`endif
                end else begin
                    if (writes_sp) begin
                        sp_d = result;
                    end else begin
                        pc_d = result;
                    end
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_FAULT: begin
                if (bus.fault_clear) begin
                    fault_d = 1'b0;
                    code_d  = FC_NONE;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= PC_RESET;
            sp_q    <= SP_RESET;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

    // NOTE: the command register is left out of reset; it is always written on
    // accept before EXEC reads it, so a reset value would buy nothing.
    always_ff @(posedge clk) begin
        op_q      <= op_d;
        operand_q <= operand_d;
    end

    assign bus.cmd_ready  = (state_q == S_IDLE);
    assign bus.pc_out     = pc_q;
    assign bus.sp_out     = sp_q;
    assign bus.done       = done_q;
    assign bus.fault      = fault_q;
    assign bus.fault_code = code_q;

endmodule

// File: tb/tb_pc_sp_update_unit.sv
// Bench for pc_sp_update_unit: directed scenarios, then random commands checked
// against an arithmetic model of the PC/SP rules.
module tb_pc_sp_update_unit;
    localparam int          WIDTH     = 16;
    localparam int          IMM_W     = 10;
    localparam int          IMM_SHIFT = 1;
    localparam int          PC_STEP   = 2;
    localparam logic [15:0] PC_RESET  = 16'h0000;
    localparam logic [15:0] SP_RESET  = 16'hFFFE;

    logic clk = 1'b0;
    logic reset;

    pc_sp_update_unit_if #(.WIDTH(WIDTH), .IMM_W(IMM_W)) bus ();

    pc_sp_update_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] pc_m, sp_m, limit_m;
    logic        fault_m;
    logic [1:0]  code_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ext_of(input logic [9:0] imm);
        int s;
        s = imm[9] ? int'(imm) - 1024 : int'(imm);
        return 16'(s * (1 << IMM_SHIFT));
    endfunction

    task automatic model_reset();
        pc_m    = PC_RESET;
        sp_m    = SP_RESET;
        fault_m = 1'b0;
        code_m  = 2'b00;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_pc"},    bus.pc_out,     pc_m);
        check({tag, "_sp"},    bus.sp_out,     sp_m);
        check({tag, "_fault"}, bus.fault,      fault_m);
        check({tag, "_code"},  bus.fault_code, code_m);
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [9:0] imm, input logic [15:0] data);
        logic [15:0] res;
        logic        fl;
        logic [1:0]  cd;
        int          waited;
        waited = 0;
        while (bus.cmd_ready !== 1'b1 && waited < 4) begin
            tick();
            waited++;
        end
        check("ready_before_accept", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_imm   = imm;
        bus.cmd_data  = data;
        tick();
        // Inputs change while the command executes; they must not matter.
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_op    = 2'($urandom);
        bus.cmd_imm   = 10'($urandom);
        bus.cmd_data  = 16'($urandom);
        check("exec_ready", bus.cmd_ready, 0);
        check("exec_done",  bus.done, 0);
        check("exec_pc",    bus.pc_out, pc_m);
        check("exec_sp",    bus.sp_out, sp_m);

        fl = 1'b0;
        cd = 2'b00;
        case (op)
            2'd0:    res = sp_m + ext_of(imm);
            2'd1:    res = pc_m + ext_of(imm);
            2'd2:    res = pc_m + 16'(PC_STEP);
            default: res = data;
        endcase
        if (op != 2'd0 && res[0]) begin
            fl = 1'b1;
            cd = 2'b01;
        end
`ifdef PC_SP_STACK_LIMIT_EN
        if (op == 2'd0 && res < limit_m) begin
            fl = 1'b1;
            cd = 2'b10;
        end
`endif
        if (fl) begin
            fault_m = 1'b1;
            code_m  = cd;
        end else if (op == 2'd0) begin
            sp_m = res;
        end else begin
            pc_m = res;
        end

        tick();
        bus.cmd_valid = 1'b0;
        check_state("retire");
        check("retire_done",  bus.done, !fl);
        check("retire_ready", bus.cmd_ready, !fl);
    endtask

    task automatic clear_fault();
        bus.fault_clear = 1'b1;
        tick();
        bus.fault_clear = 1'b0;
        fault_m = 1'b0;
        code_m  = 2'b00;
        check_state("clear");
        check("clear_ready", bus.cmd_ready, 1);
    endtask

    initial begin
        limit_m = 16'h0000;
`ifdef PC_SP_STACK_LIMIT_EN
        bus.stack_limit = limit_m;
`endif
        model_reset();

        // Reset dominates a pending command and a fault_clear.
        reset           = 1'b1;
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = 2'b11;
        bus.cmd_imm     = 10'h000;
        bus.cmd_data    = 16'h1235;
        bus.fault_clear = 1'b1;
        repeat (3) begin
            tick();
            check_state("reset");
            check("reset_ready", bus.cmd_ready, 1);
            check("reset_done",  bus.done, 0);
        end
        reset           = 1'b0;
        bus.cmd_valid   = 1'b0;
        bus.fault_clear = 1'b0;
        tick();
        check_state("post_reset");

        // fault_clear outside FAULT is ignored.
        bus.fault_clear = 1'b1;
        tick();
        bus.fault_clear = 1'b0;
        check_state("stray_clear");
        check("stray_clear_ready", bus.cmd_ready, 1);

        do_cmd(2'd0, 10'h3FE, 16'h0);
        check("tp_sp_fffa", bus.sp_out, 16'hFFFA);
        check("tp_pc_0000", bus.pc_out, 16'h0000);
        tick();
        check("done_one_cycle", bus.done, 0);

        do_cmd(2'd1, 10'h1FF, 16'h0);
        check("tp_pc_03fe", bus.pc_out, 16'h03FE);
        do_cmd(2'd1, 10'h200, 16'h0);
        check("tp_pc_fffe", bus.pc_out, 16'hFFFE);

        do_cmd(2'd2, 10'h000, 16'h0);
        check("tp_wrap_pc", bus.pc_out, 16'h0000);

        // Misaligned load faults and holds off commands until cleared.
        do_cmd(2'd3, 10'h000, 16'h1235);
        check("tp_misalign_code", bus.fault_code, 2'b01);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd2;
        repeat (5) begin
            tick();
            check("fault_hold_ready", bus.cmd_ready, 0);
            check_state("fault_hold");
        end
        bus.cmd_valid = 1'b0;
        clear_fault();

        // Held cmd_valid: one accept every other cycle.
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd2;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k % 2 == 0) pc_m = pc_m + 16'(PC_STEP);
            check("b2b_ready", bus.cmd_ready, (k % 2 == 0));
            check("b2b_done",  bus.done, (k % 2 == 0));
            check("b2b_pc",    bus.pc_out, pc_m);
        end
        bus.cmd_valid = 1'b0;
        check("tp_b2b_pc_0006", bus.pc_out, 16'h0006);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [15:0] data;
            op   = 2'($urandom_range(0, 3));
            data = 16'($urandom);
            if ($urandom_range(0, 2) != 0) data[0] = 1'b0;
            do_cmd(op, 10'($urandom), data);
            if (fault_m) clear_fault();
        end

        // Reset lands while a command is in EXEC.
        tick();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd3;
        bus.cmd_data  = 16'h4444;
        tick();
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        tick();
        reset = 1'b0;
        model_reset();
        check_state("reset_in_exec");
        check("reset_in_exec_done", bus.done, 0);

`ifdef PC_SP_STACK_LIMIT_EN
        do_cmd(2'd0, 10'h382, 16'h0);
        check("tp_sp_ff02", bus.sp_out, 16'hFF02);
        limit_m         = 16'hFF00;
        bus.stack_limit = limit_m;
        do_cmd(2'd0, 10'h3FE, 16'h0);
        check("tp_limit_code", bus.fault_code, 2'b10);
        check("tp_limit_sp",   bus.sp_out, 16'hFF02);
        clear_fault();
        do_cmd(2'd0, 10'h3FF, 16'h0);
        check("tp_limit_exact", bus.sp_out, 16'hFF00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
